// File: rtl/mastermind_pkg.sv
// Shared MasterMind types: symbol/count widths and the scorer FSM encoding,
// used by the digit-entry, display and scoring stages alike.
package mastermind_pkg;

  localparam int DIGITS   = 4;
  localparam int SYM_BITS = 4;

  typedef logic [SYM_BITS-1:0]          sym_t;
  typedef logic [$clog2(DIGITS+1)-1:0]  count_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    EXACT_PASS   = 2'd1,
    PARTIAL_PASS = 2'd2,
    REPORT       = 2'd3
  } scorer_state_t;

endpackage

// File: rtl/mastermind_scorer.sv
// Sequential MasterMind guess scorer with win/try tracking; one symbol comparator
// reused across an exact pass and a pairwise colour pass.
// Option: MASTERMIND_SCORER_TRY_LIMIT_EN ends the game after MAX_TRIES guesses.
module mastermind_scorer
  import mastermind_pkg::*;
#(
  parameter int DIGITS    = mastermind_pkg::DIGITS,
  parameter int SYM_BITS  = mastermind_pkg::SYM_BITS,
  parameter int MAX_TRIES = 10
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  input  logic                           NEW_GAME,
  input  logic [DIGITS*SYM_BITS-1:0]     GUESS,
  input  logic [DIGITS*SYM_BITS-1:0]     SECRET,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [$clog2(DIGITS+1)-1:0]    EXACT,
  output logic [$clog2(DIGITS+1)-1:0]    PARTIAL,
  output logic                           WIN,
  output logic [$clog2(MAX_TRIES+1)-1:0] TRIES,
  output logic                           GAME_OVER
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = DIGITS * SYM_BITS;

  scorer_state_t   state_r;
  scorer_state_t   state_n_s;
  logic [GW-1:0]     guess_r;
  logic [GW-1:0]     secret_r;
  logic [DIGITS-1:0] used_g_r;
  logic [DIGITS-1:0] used_s_r;
  logic [IW-1:0]     i_r;
  logic [IW-1:0]     j_r;
  logic [CW-1:0]     exact_cnt_r;
  logic [CW-1:0]     partial_cnt_r;
  logic [CW-1:0]     exact_r;
  logic [CW-1:0]     partial_r;
  logic [TW-1:0]     tries_r;
  logic [TW-1:0]     tries_n_s;
  logic              win_r;
  logic              game_over_r;
  logic              done_r;
  logic              busy_r;
  logic              start_ok_s;
  logic              i_last_s;
  logic              j_last_s;
  logic              win_n_s;
  logic              game_over_n_s;
  logic [SYM_BITS-1:0] sym_g_s;
  logic [SYM_BITS-1:0] sym_s_s;
  logic              sym_eq_s;
  logic              partial_hit_s;

  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign EXACT     = exact_r;
  assign PARTIAL   = partial_r;
  assign WIN       = win_r;
  assign TRIES     = tries_r;
  assign GAME_OVER = game_over_r;

  // Single shared comparator: secret index follows i in the exact pass, j otherwise.
  always_comb begin
    sym_g_s = guess_r[i_r*SYM_BITS +: SYM_BITS];
    if (state_r == EXACT_PASS) begin
      sym_s_s = secret_r[i_r*SYM_BITS +: SYM_BITS];
    end else begin
      sym_s_s = secret_r[j_r*SYM_BITS +: SYM_BITS];
    end
    sym_eq_s      = (sym_g_s == sym_s_s);
    partial_hit_s = sym_eq_s & ~used_g_r[i_r] & ~used_s_r[j_r];
    i_last_s      = (i_r == IW'(DIGITS - 1));
    j_last_s      = (j_r == IW'(DIGITS - 1));
    start_ok_s    = START & ~game_over_r;
  end

  // Outcome of the score being reported this cycle.
  always_comb begin
    win_n_s = (exact_cnt_r == CW'(DIGITS));
`ifdef MASTERMIND_SCORER_TRY_LIMIT_EN
    if (tries_r == TW'(MAX_TRIES)) begin
      tries_n_s = tries_r;
    end else begin
      tries_n_s = tries_r + TW'(1);
    end
    game_over_n_s = win_n_s | (tries_n_s == TW'(MAX_TRIES));
`else
    if (tries_r == {TW{1'b1}}) begin
      tries_n_s = tries_r;
    end else begin
      tries_n_s = tries_r + TW'(1);
    end
    game_over_n_s = win_n_s;
`endif
  end

  // FSM next state; NEW_GAME overrides everything, including a same-cycle START.
  always_comb begin
    state_n_s = state_r;
    if (NEW_GAME) begin
      state_n_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_n_s = EXACT_PASS;
          end else begin
            state_n_s = IDLE;
          end
        end
        EXACT_PASS: begin
          if (i_last_s) begin
            state_n_s = PARTIAL_PASS;
          end else begin
            state_n_s = EXACT_PASS;
          end
        end
        PARTIAL_PASS: begin
          if (i_last_s && j_last_s) begin
            state_n_s = REPORT;
          end else begin
            state_n_s = PARTIAL_PASS;
          end
        end
        REPORT:  state_n_s = IDLE;
        default: state_n_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath: operand latches, index counters, working counts and reported results.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      guess_r       <= {GW{1'b0}};
      secret_r      <= {GW{1'b0}};
      used_g_r      <= {DIGITS{1'b0}};
      used_s_r      <= {DIGITS{1'b0}};
      i_r           <= {IW{1'b0}};
      j_r           <= {IW{1'b0}};
      exact_cnt_r   <= {CW{1'b0}};
      partial_cnt_r <= {CW{1'b0}};
      exact_r       <= {CW{1'b0}};
      partial_r     <= {CW{1'b0}};
      tries_r       <= {TW{1'b0}};
      win_r         <= 1'b0;
      game_over_r   <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else if (NEW_GAME) begin
      used_g_r      <= {DIGITS{1'b0}};
      used_s_r      <= {DIGITS{1'b0}};
      i_r           <= {IW{1'b0}};
      j_r           <= {IW{1'b0}};
      exact_cnt_r   <= {CW{1'b0}};
      partial_cnt_r <= {CW{1'b0}};
      exact_r       <= {CW{1'b0}};
      partial_r     <= {CW{1'b0}};
      tries_r       <= {TW{1'b0}};
      win_r         <= 1'b0;
      game_over_r   <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_n_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            guess_r       <= GUESS;
            secret_r      <= SECRET;
            used_g_r      <= {DIGITS{1'b0}};
            used_s_r      <= {DIGITS{1'b0}};
            i_r           <= {IW{1'b0}};
            j_r           <= {IW{1'b0}};
            exact_cnt_r   <= {CW{1'b0}};
            partial_cnt_r <= {CW{1'b0}};
          end
        end
        EXACT_PASS: begin
          if (sym_eq_s) begin
            exact_cnt_r   <= exact_cnt_r + CW'(1);
            used_g_r[i_r] <= 1'b1;
            used_s_r[i_r] <= 1'b1;
          end
          i_r <= i_last_s ? {IW{1'b0}} : i_r + IW'(1);
        end
        PARTIAL_PASS: begin
          if (partial_hit_s) begin
            partial_cnt_r <= partial_cnt_r + CW'(1);
            used_g_r[i_r] <= 1'b1;
            used_s_r[j_r] <= 1'b1;
          end
          if (j_last_s) begin
            j_r <= {IW{1'b0}};
            i_r <= i_last_s ? {IW{1'b0}} : i_r + IW'(1);
          end else begin
            j_r <= j_r + IW'(1);
          end
        end
        REPORT: begin
          exact_r     <= exact_cnt_r;
          partial_r   <= partial_cnt_r;
          win_r       <= win_n_s;
          tries_r     <= tries_n_s;
          game_over_r <= game_over_n_s;
          done_r      <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Self-checking bench for mastermind_scorer: directed scenarios plus random
// guesses scored by a colour-count reference model.
module tb_mastermind_scorer;

  localparam int D  = 4;
  localparam int SB = 4;
  localparam int MT = 10;
  localparam int CW = 3;
  localparam int TW = 4;
`ifdef MASTERMIND_SCORER_TRY_LIMIT_EN
  localparam int TRY_SAT = MT;
`else
  localparam int TRY_SAT = (1 << TW) - 1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          NEW_GAME;
  logic [15:0]   GUESS;
  logic [15:0]   SECRET;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] EXACT;
  logic [CW-1:0] PARTIAL;
  logic          WIN;
  logic [TW-1:0] TRIES;
  logic          GAME_OVER;

  int tests = 0;
  int fails = 0;
  int m_tries = 0;
  bit m_win = 1'b0;
  bit m_go = 1'b0;

  mastermind_scorer #(.DIGITS(D), .SYM_BITS(SB), .MAX_TRIES(MT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .NEW_GAME(NEW_GAME),
    .GUESS(GUESS), .SECRET(SECRET), .BUSY(BUSY), .DONE(DONE),
    .EXACT(EXACT), .PARTIAL(PARTIAL), .WIN(WIN), .TRIES(TRIES),
    .GAME_OVER(GAME_OVER)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact = same symbol same place; partial = per-colour overlap minus exact.
  function automatic void ref_score(input logic [15:0] g, input logic [15:0] s,
                                    output int ex, output int pa);
    int cg[16];
    int cs[16];
    for (int c = 0; c < 16; c++) begin
      cg[c] = 0;
      cs[c] = 0;
    end
    ex = 0;
    pa = 0;
    for (int k = 0; k < D; k++) begin
      if (g[k*SB +: SB] == s[k*SB +: SB]) ex++;
      cg[g[k*SB +: SB]]++;
      cs[s[k*SB +: SB]]++;
    end
    for (int c = 0; c < 16; c++) pa += (cg[c] < cs[c]) ? cg[c] : cs[c];
    pa -= ex;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"}, BUSY, 0);
    chk({tag, ".done"}, DONE, 0);
    chk({tag, ".exact"}, EXACT, 0);
    chk({tag, ".partial"}, PARTIAL, 0);
    chk({tag, ".win"}, WIN, 0);
    chk({tag, ".tries"}, TRIES, 0);
    chk({tag, ".game_over"}, GAME_OVER, 0);
  endtask

  task automatic new_game(input string tag);
    NEW_GAME = 1'b1;
    cyc();
    NEW_GAME = 1'b0;
    m_tries = 0;
    m_win = 1'b0;
    m_go = 1'b0;
    chk({tag, ".ng_tries"}, TRIES, 0);
    chk({tag, ".ng_go"}, GAME_OVER, 0);
    chk({tag, ".ng_busy"}, BUSY, 0);
  endtask

  // Pulse START and check latency and results against the model.
  task automatic score(input logic [15:0] g, input logic [15:0] s, input string tag);
    int ex;
    int pa;
    int n;
    int dones;
    GUESS = g;
    SECRET = s;
    START = 1'b1;
    cyc();
    START = 1'b0;
    if (m_go) begin
      chk({tag, ".ignored_busy"}, BUSY, 0);
      dones = 0;
      for (int k = 0; k < 25; k++) begin
        cyc();
        if (DONE === 1'b1) dones++;
      end
      chk({tag, ".ignored_dones"}, dones, 0);
      chk({tag, ".ignored_tries"}, TRIES, m_tries);
    end else begin
      chk({tag, ".busy"}, BUSY, 1);
      n = 0;
      while (DONE !== 1'b1 && n < 40) begin
        cyc();
        n++;
      end
      chk({tag, ".latency"}, n, 21);
      ref_score(g, s, ex, pa);
      m_win = (ex == D);
      m_tries = (m_tries < TRY_SAT) ? m_tries + 1 : m_tries;
`ifdef MASTERMIND_SCORER_TRY_LIMIT_EN
      m_go = m_win || (m_tries == MT);
`else
      m_go = m_win;
`endif
      chk({tag, ".exact"}, EXACT, ex);
      chk({tag, ".partial"}, PARTIAL, pa);
      chk({tag, ".win"}, WIN, m_win);
      chk({tag, ".tries"}, TRIES, m_tries);
      chk({tag, ".game_over"}, GAME_OVER, m_go);
      chk({tag, ".busy_fall"}, BUSY, 0);
      cyc();
      chk({tag, ".done_pulse"}, DONE, 0);
    end
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] v;
    for (int k = 0; k < D; k++) v[k*SB +: SB] = 4'($urandom_range(3, 0));
    return v;
  endfunction

  initial begin
    int n;
    int dones;
    int ex;
    int pa;
    logic [15:0] s;
    logic [15:0] g;
    RST = 1'b1;
    START = 1'b0;
    NEW_GAME = 1'b0;
    GUESS = 16'h0000;
    SECRET = 16'h0000;
    repeat (3) cyc();
    RST = 1'b0;
    check_all_zero("reset");

    score(16'h4321, 16'h4321, "win");
    chk("win.exact4", EXACT, 4);
    chk("win.tries1", TRIES, 1);

    // NEW_GAME with START in the same cycle while the game is over.
    GUESS = 16'h4321;
    SECRET = 16'h4321;
    NEW_GAME = 1'b1;
    START = 1'b1;
    cyc();
    NEW_GAME = 1'b0;
    START = 1'b0;
    m_tries = 0;
    m_win = 1'b0;
    m_go = 1'b0;
    check_all_zero("ng_start");
    repeat (3) cyc();
    chk("ng_start.busy_later", BUSY, 0);

    score(16'h1234, 16'h4321, "perm");
    chk("perm.partial4", PARTIAL, 4);
    score(16'h1121, 16'h2211, "dups");
    chk("dups.exact1", EXACT, 1);
    chk("dups.partial2", PARTIAL, 2);

    // Second START mid-scoring with a different guess must be ignored.
    GUESS = 16'h4312;
    SECRET = 16'h4321;
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (5) cyc();
    GUESS = 16'h4321;
    START = 1'b1;
    cyc();
    START = 1'b0;
    n = 6;
    dones = 0;
    while (n < 45) begin
      if (DONE === 1'b1) begin
        dones++;
        chk("restart.latency", n, 21);
        chk("restart.exact", EXACT, 2);
        chk("restart.partial", PARTIAL, 2);
        chk("restart.win", WIN, 0);
      end
      cyc();
      n++;
    end
    chk("restart.dones", dones, 1);
    m_tries = m_tries + 1;
    chk("restart.tries", TRIES, m_tries);

    // Asynchronous reset in the middle of scoring.
    GUESS = 16'h1111;
    SECRET = 16'h4321;
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (10) cyc();
    RST = 1'b1;
    #1;
    check_all_zero("rst_mid");
    cyc();
    RST = 1'b0;
    m_tries = 0;
    m_win = 1'b0;
    m_go = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (DONE === 1'b1) dones++;
    end
    chk("rst_mid.dones", dones, 0);
    score(16'h3312, 16'h4321, "after_rst");
    chk("after_rst.tries1", TRIES, 1);

    // Long run of wrong guesses: try saturation and (optionally) try-limit game over.
    new_game("sat");
    for (int k = 0; k < 17; k++) begin
      s = rand_code();
      score(s ^ 16'h0001, s, $sformatf("sat%0d", k));
    end
    chk("sat.tries", TRIES, TRY_SAT);
`ifdef MASTERMIND_SCORER_TRY_LIMIT_EN
    chk("sat.game_over", GAME_OVER, 1);
`else
    chk("sat.game_over", GAME_OVER, 0);
`endif

    // Random games with small symbol alphabet to exercise duplicates.
    new_game("rnd");
    for (int k = 0; k < 60; k++) begin
      if (m_go) new_game($sformatf("rnd_ng%0d", k));
      s = rand_code();
      g = ($urandom_range(7, 0) == 0) ? s : rand_code();
      score(g, s, $sformatf("rnd%0d", k));
    end
    ref_score(16'h0000, 16'h0000, ex, pa);
    chk("model.sanity_exact", ex, 4);
    chk("model.sanity_partial", pa, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mastermind_scorer.md
# mastermind_scorer

- Scores one MasterMind guess against the secret code and tracks game progress.
- Sits downstream of the digit-entry/display stage: consumes the four 4-bit digit values the player edits, plus the secret.
- Produces exact-hit and colour-hit counts, a win flag and a try counter for the display/LED stage.
- Scoring is a sequential pair-by-pair comparison, so it uses no wide combinational compare network.

## Interface
Parameters:
- DIGITS, 4, code length in symbols
- SYM_BITS, 4, bits per symbol; matches the value field of a display digit
- MAX_TRIES, 10, guesses allowed per game

Ports:
- CLK  in  1  system clock (PLL output domain)
- RST  in  1  reset; asynchronous, active-high
- START  in  1  one-cycle pulse; request scoring of GUESS against SECRET
- NEW_GAME  in  1  one-cycle pulse; clear game state
- GUESS  in  DIGITS*SYM_BITS  packed guess; digit 0 at LSBs
- SECRET  in  DIGITS*SYM_BITS  packed secret; digit 0 at LSBs
- BUSY  out  1  scoring in progress
- DONE  out  1  one-cycle pulse when results update
- EXACT  out  $clog2(DIGITS+1)  right symbol in the right position
- PARTIAL  out  $clog2(DIGITS+1)  right symbol in the wrong position
- WIN  out  1  last score had EXACT==DIGITS
- TRIES  out  $clog2(MAX_TRIES+1)  guesses scored this game
- GAME_OVER  out  1  no further guesses accepted

## Operation
- FSM states: IDLE, EXACT_PASS, PARTIAL_PASS, REPORT.
- IDLE:
  - START accepted only when GAME_OVER=0.
  - On accept: latch GUESS and SECRET, clear the working counters and the used_g/used_s masks (DIGITS bits each), go to EXACT_PASS.
- EXACT_PASS: one position i per cycle, i=0..DIGITS-1. If g[i]==s[i]: increment the exact counter and set used_g[i] and used_s[i].
- PARTIAL_PASS:
  - One (i,j) pair per cycle, i outer, j inner, i,j=0..DIGITS-1; always DIGITS² cycles, with no early exit.
  - If !used_g[i] && !used_s[j] && g[i]==s[j]: increment the partial counter and set used_g[i] and used_s[j].
- REPORT (one cycle):
  - Copy the working counters to EXACT and PARTIAL.
  - WIN <= (exact==DIGITS).
  - TRIES increments, saturating at MAX_TRIES.
  - Pulse DONE, return to IDLE.
- EXACT, PARTIAL and WIN hold their values between REPORT cycles.
- GAME_OVER = WIN | (TRIES==MAX_TRIES), registered.
- START while BUSY: ignored and not queued. START while GAME_OVER=1: ignored.
- NEW_GAME has priority over everything:
  - From any state, the next cycle is IDLE.
  - EXACT, PARTIAL, WIN, TRIES and GAME_OVER are cleared to 0.
  - An aborted scoring produces no DONE.
  - START in the same cycle as NEW_GAME is dropped.
- Counter arithmetic is unsigned and cannot overflow: the maximum count is DIGITS.

## Timing
- Reset values: BUSY=0, DONE=0, EXACT=0, PARTIAL=0, WIN=0, TRIES=0, GAME_OVER=0; FSM in IDLE.
- Latency: START is sampled at edge t. BUSY is high from t+1. DONE is high in the cycle following edge t+1+DIGITS+DIGITS².
  - For DIGITS=4 this is 21 cycles after the sampling edge.
- BUSY falls together with DONE.
- Results, WIN, TRIES and GAME_OVER change only on the edge that raises DONE, or on NEW_GAME/RST.
- RST asserted mid-operation: all outputs return to reset values immediately, with no DONE.
- GUESS and SECRET may change freely while BUSY; only the latched copies are used.

## Configuration
- MASTERMIND_SCORER_TRY_LIMIT_EN defined:
  - TRIES saturates at MAX_TRIES.
  - GAME_OVER also asserts when TRIES==MAX_TRIES.
- Undefined:
  - TRIES saturates at its all-ones value.
  - GAME_OVER = WIN only; MAX_TRIES affects only the TRIES width.

## Structure
- Shared package mastermind_pkg holds:
  - constants DIGITS and SYM_BITS
  - typedef sym_t (logic [SYM_BITS-1:0])
  - typedef count_t (logic [$clog2(DIGITS+1)-1:0])
  - the enum scorer_state_t
- These are shared so the digit-entry and display stages use the same symbol width.
- No sub-module: the FSM, the index counters and a single symbol comparator live in one module.

## Test plan
- Secret digits [1,2,3,4] (SECRET=16'h4321), GUESS=16'h4321, START -> DONE exactly 21 cycles later; EXACT=4, PARTIAL=0, WIN=1, GAME_OVER=1, TRIES=1.
- Secret 16'h4321, GUESS=16'h1234 -> EXACT=0, PARTIAL=4, WIN=0. Secret 16'h2211, GUESS=16'h1121 -> EXACT=1, PARTIAL=2 (duplicate handling).
- With MASTERMIND_SCORER_TRY_LIMIT_EN: 10 wrong guesses -> GAME_OVER=1 after the 10th DONE, TRIES=10. An 11th START -> BUSY stays 0 and no DONE.
- START again 5 cycles into scoring, with GUESS changed -> ignored; results match the first GUESS, and exactly one DONE.
- RST pulse 10 cycles after START -> all outputs 0, no DONE. A new START then scores normally with TRIES=1.
- NEW_GAME and START in the same cycle during GAME_OVER=1 -> all state cleared, BUSY stays 0. The next START alone scores normally.
